dcm_prog_ctrl: RTL and testbench
================================

// Module: dcm_prog_ctrl
// PURPOSE
//   User-facing configuration controller for the clock-divider block. Debounces up/down/load
//   buttons, edits a pending 3-bit divider selection, commits it with a one-cycle update
//   pulse, then confirms the divider's readback (prog_out) before accepting a new request.
//   Sits between board pushbuttons and the divider's prog/update/prog_out ports.
// PARAMETERS
//   DEBOUNCE_CYCLES  500000  cycles a button must be stable-high to count as a press (10 ms @ 50 MHz)
//   CONFIRM_TIMEOUT  4       cycles allowed in CONFIRM for readback to match before err
//   WRAP             0       0: pending saturates at 0/7; 1: pending wraps 7->0 and 0->7
//   RESET_PROG       0       reset value of pending and prog (matches divider reset selection)
// PORTS
//   clk       in   1  system clock
//   rst       in   1  asynchronous, active-low reset
//   btn_up    in   1  raw button, increment pending (synchronised internally, 2 flops)
//   btn_down  in   1  raw button, decrement pending
//   btn_load  in   1  raw button, commit pending to divider
//   prog_fb   in   3  divider readback of its latched selection
//   prog      out  3  selection driven to divider; changes only on commit
//   update    out  1  one-cycle commit strobe to divider
//   pending   out  3  edited, not-yet-committed selection (for display)
//   busy      out  1  high in COMMIT and CONFIRM
//   err       out  1  sticky: last commit failed readback; cleared by next commit
// BEHAVIOUR
//   Reset (rst=0, async): prog=pending=RESET_PROG, update=0, busy=0, err=0, state IDLE,
//     debounce counters and synchronisers cleared; a commit in flight is abandoned.
//   Debounce: per button, counter increments while synchronised input high, clears when low;
//     press event = single-cycle pulse the cycle counter reaches DEBOUNCE_CYCLES-1; no repeat
//     until input returns low. Total latency raw-high -> event: DEBOUNCE_CYCLES+2 cycles.
//   Edit (any state): up event -> pending+1, down event -> pending-1, effective next cycle.
//     At 7 with up / 0 with down: hold (WRAP=0) or wrap mod 8 (WRAP=1). Up and down events
//     in the same cycle: both ignored. Edits while busy are allowed; they affect next commit.
//   FSM (2-bit, states in package):
//     IDLE    : load event -> COMMIT. Load event in COMMIT/CONFIRM ignored (not queued).
//     COMMIT  : one cycle; prog<=pending, update=1, err<=0, timeout counter cleared -> CONFIRM.
//     CONFIRM : update=0; each cycle compare prog_fb to prog. Match -> IDLE (err stays 0).
//               No match after CONFIRM_TIMEOUT cycles -> err<=1, IDLE. prog keeps committed value.
//   update is registered: high exactly one cycle per commit; never high in IDLE/CONFIRM.
//   busy = (state != IDLE), registered alongside state.
//   Load and edit event in same IDLE cycle: commit uses pending before the edit.
//   Width rules: pending/prog 3 bits unsigned; timeout counter sized $clog2(CONFIRM_TIMEOUT+1);
//     debounce counter sized $clog2(DEBOUNCE_CYCLES), saturating, never wraps.
// STRUCTURE
//   Package dcm_pkg: state encoding (ST_IDLE, ST_COMMIT, ST_CONFIRM), PROG_W=3, PROG_MAX=7.
//   Sub-module btn_debounce (sync + counter + edge pulse), instantiated three times.
//   Top holds pending/prog registers, FSM and timeout counter.
// TESTING (bench uses DEBOUNCE_CYCLES=4, CONFIRM_TIMEOUT=4, simple divider model echoing prog)
//   Reset -> prog=0,pending=0,update=0,busy=0,err=0; btn_up high 6 cycles -> exactly one event, pending=1.
//   Three up presses then load -> update pulses 1 cycle with prog=3, busy 1 then 0 when prog_fb=3, err=0.
//   WRAP=0: pending=7, up press -> stays 7; WRAP=1: pending=7, up -> 0; pending=0, down -> 7.
//   Divider model stuck at prog_fb=0, commit prog=5 -> after 4 CONFIRM cycles err=1, busy=0, prog=5.
//   Load pressed again during CONFIRM -> no second update pulse; up+down events same cycle -> pending unchanged.
//   rst low during COMMIT -> update drops immediately, all outputs at reset values, FSM restarts in IDLE.

Source files
------------

// File: rtl/dcm_pkg.sv
// Shared definitions for the divider configuration controller: selection width,
// FSM state encoding and the pending-selection edit rule.
package dcm_pkg;

    localparam int PROG_W = 3;
    localparam logic [PROG_W-1:0] PROG_MAX = 3'd7;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_COMMIT  = 2'd1;
    localparam logic [1:0] ST_CONFIRM = 2'd2;

    // Simultaneous up and down cancel out; the ends either hold or wrap.
    function automatic logic [PROG_W-1:0] next_sel(
        input logic [PROG_W-1:0] cur,
        input logic              up,
        input logic              down,
        input logic              wrap
    );
        next_sel = cur;
        if (up && !down) begin
            if (cur == PROG_MAX)
                next_sel = wrap ? '0 : PROG_MAX;
            else
                next_sel = cur + PROG_W'(1);
        end else if (down && !up) begin
            if (cur == '0)
                next_sel = wrap ? PROG_MAX : '0;
            else
                next_sel = cur - PROG_W'(1);
        end
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchroniser plus stable-high counter; emits one pulse per press,
// DEBOUNCE_CYCLES+2 cycles after the raw input rises.
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic clk,
    input  logic rst,
    input  logic i_btn,
    output logic o_press
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic             r_sync1;
    logic             r_sync2;
    logic [CNT_W-1:0] r_cnt;
    logic             r_press;

    // Counter saturates at CNT_MAX, so the pre-max value is seen once per high period.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_cnt   <= '0;
            r_press <= 1'b0;
        end else begin
            r_sync1 <= i_btn;
            r_sync2 <= r_sync1;
            if (!r_sync2)
                r_cnt <= '0;
            else if (r_cnt != CNT_MAX)
                r_cnt <= r_cnt + CNT_ONE;
            r_press <= r_sync2 && (r_cnt == CNT_MAX - CNT_ONE);
        end
    end

    assign o_press = r_press;

endmodule

// File: rtl/dcm_prog_ctrl.sv
// Pushbutton front end for the clock divider: edits a pending selection, commits it
// with a one-cycle update strobe and confirms the divider readback.
module dcm_prog_ctrl
    import dcm_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int CONFIRM_TIMEOUT = 4,
    parameter int WRAP            = 0,
    parameter int RESET_PROG      = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              btn_up,
    input  logic              btn_down,
    input  logic              btn_load,
    input  logic [PROG_W-1:0] prog_fb,
    output logic [PROG_W-1:0] prog,
    output logic              update,
    output logic [PROG_W-1:0] pending,
    output logic              busy,
    output logic              err
);

    localparam int TMO_W = $clog2(CONFIRM_TIMEOUT + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(CONFIRM_TIMEOUT - 1);
    localparam logic [TMO_W-1:0] TMO_ONE  = TMO_W'(1);
    localparam logic [PROG_W-1:0] RST_SEL = PROG_W'(RESET_PROG);

    logic w_up;
    logic w_down;
    logic w_load;

    logic [1:0]        r_state;
    logic              r_busy;
    logic              r_update;
    logic              r_err;
    logic [PROG_W-1:0] r_prog;
    logic [PROG_W-1:0] r_pending;
    logic [TMO_W-1:0]  r_tmo;

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_up (
        .clk(clk), .rst(rst), .i_btn(btn_up), .o_press(w_up)
    );
    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_down (
        .clk(clk), .rst(rst), .i_btn(btn_down), .o_press(w_down)
    );
    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_load (
        .clk(clk), .rst(rst), .i_btn(btn_load), .o_press(w_load)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            r_pending <= RST_SEL;
        else
            r_pending <= next_sel(r_pending, w_up, w_down, WRAP != 0);
    end

    // Commit values are loaded on the IDLE->COMMIT edge, so prog takes the pre-edit pending
    // and update is high for exactly the COMMIT cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= ST_IDLE;
            r_busy   <= 1'b0;
            r_update <= 1'b0;
            r_err    <= 1'b0;
            r_prog   <= RST_SEL;
            r_tmo    <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_load) begin
                        r_state  <= ST_COMMIT;
                        r_busy   <= 1'b1;
                        r_update <= 1'b1;
                        r_prog   <= r_pending;
                        r_err    <= 1'b0;
                        r_tmo    <= '0;
                    end
                end
                ST_COMMIT: begin
                    r_state  <= ST_CONFIRM;
                    r_update <= 1'b0;
                end
                ST_CONFIRM: begin
                    if (prog_fb == r_prog) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end else if (r_tmo == TMO_LAST) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                        r_err   <= 1'b1;
                    end else begin
                        r_tmo <= r_tmo + TMO_ONE;
                    end
                end
                default: begin
                    r_state  <= ST_IDLE;
                    r_busy   <= 1'b0;
                    r_update <= 1'b0;
                end
            endcase
        end
    end

    assign prog    = r_prog;
    assign update  = r_update;
    assign pending = r_pending;
    assign busy    = r_busy;
    assign err     = r_err;

endmodule

// File: tb/tb_dcm_prog_ctrl.sv
// Directed bench: dut0 is the saturating build, dut1 the wrapping build with a longer
// confirm window so a re-debounced load can land inside CONFIRM.
module tb_dcm_prog_ctrl;

    logic       clk;
    logic       rst;
    logic       btn_up;
    logic       btn_down;
    logic       btn_load;
    logic       stuck;

    logic [2:0] prog0, pend0, fb0, fbr0;
    logic       upd0, busy0, err0;
    logic [2:0] prog1, pend1, fb1, fbr1;
    logic       upd1, busy1, err1;

    int n_chk  = 0;
    int n_fail = 0;
    int np0    = 0;
    int np1    = 0;

    dcm_prog_ctrl #(
        .DEBOUNCE_CYCLES(4), .CONFIRM_TIMEOUT(4), .WRAP(0), .RESET_PROG(0)
    ) dut0 (
        .clk(clk), .rst(rst), .btn_up(btn_up), .btn_down(btn_down), .btn_load(btn_load),
        .prog_fb(fb0), .prog(prog0), .update(upd0), .pending(pend0), .busy(busy0), .err(err0)
    );

    dcm_prog_ctrl #(
        .DEBOUNCE_CYCLES(4), .CONFIRM_TIMEOUT(8), .WRAP(1), .RESET_PROG(0)
    ) dut1 (
        .clk(clk), .rst(rst), .btn_up(btn_up), .btn_down(btn_down), .btn_load(btn_load),
        .prog_fb(fb1), .prog(prog1), .update(upd1), .pending(pend1), .busy(busy1), .err(err1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Divider model: latches prog on update, or reads back 0 when stuck.
    initial begin
        fbr0 = 3'd0;
        fbr1 = 3'd0;
    end
    always @(posedge clk) begin
        if (upd0) fbr0 <= prog0;
        if (upd1) fbr1 <= prog1;
    end
    assign fb0 = stuck ? 3'd0 : fbr0;
    assign fb1 = stuck ? 3'd0 : fbr1;

    always @(negedge clk) begin
        if (upd0 === 1'b1) np0++;
        if (upd1 === 1'b1) np1++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic press(input logic up, input logic down, input logic load, input int hold);
        btn_up   = up;
        btn_down = down;
        btn_load = load;
        repeat (hold) tick();
        btn_up   = 1'b0;
        btn_down = 1'b0;
        btn_load = 1'b0;
        repeat (6) tick();
    endtask

    task automatic wait_upd0(output bit found);
        found = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (upd0 === 1'b1) begin
                found = 1'b1;
                break;
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit found;
        int b0, b1;

        rst = 1'b0; btn_up = 1'b0; btn_down = 1'b0; btn_load = 1'b0; stuck = 1'b0;
        repeat (3) tick();
        chk("rst_prog", prog0, 0);
        chk("rst_pend", pend0, 0);
        chk("rst_upd", upd0, 0);
        chk("rst_busy", busy0, 0);
        chk("rst_err", err0, 0);
        chk("rst_pend1", pend1, 0);
        rst = 1'b1;
        repeat (2) tick();

        // Long hold gives exactly one increment.
        press(1'b1, 1'b0, 1'b0, 10);
        chk("one_event", pend0, 1);
        chk("one_event1", pend1, 1);
        press(1'b1, 1'b0, 1'b0, 6);
        press(1'b1, 1'b0, 1'b0, 6);
        chk("pend3", pend0, 3);

        // Commit 3 with an echoing divider.
        b0 = np0;
        btn_load = 1'b1;
        wait_upd0(found);
        chk("upd_seen3", found, 1);
        chk("commit_prog3", prog0, 3);
        chk("commit_busy", busy0, 1);
        @(negedge clk);
        chk("confirm_busy", busy0, 1);
        chk("confirm_upd", upd0, 0);
        @(negedge clk);
        chk("idle_busy", busy0, 0);
        chk("idle_err", err0, 0);
        @(posedge clk); #1;
        btn_load = 1'b0;
        repeat (8) tick();
        chk("pulses3", np0 - b0, 1);
        chk("prog3_held", prog0, 3);

        // Top end: saturate versus wrap, then wrap back down.
        repeat (4) press(1'b1, 1'b0, 1'b0, 6);
        chk("pend7", pend0, 7);
        chk("pend7w", pend1, 7);
        press(1'b1, 1'b0, 1'b0, 6);
        chk("sat_up", pend0, 7);
        chk("wrap_up", pend1, 0);
        press(1'b0, 1'b1, 1'b0, 6);
        chk("sat_down", pend0, 6);
        chk("wrap_down", pend1, 7);

        // Divider stuck at 0: commit 5 times out after four CONFIRM cycles.
        stuck = 1'b1;
        press(1'b0, 1'b1, 1'b0, 6);
        chk("pend5", pend0, 5);
        btn_load = 1'b1;
        wait_upd0(found);
        chk("upd_seen5", found, 1);
        chk("commit_prog5", prog0, 5);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("tmo_busy", busy0, 1);
            chk("tmo_err_low", err0, 0);
        end
        @(negedge clk);
        chk("tmo_busy_end", busy0, 0);
        chk("tmo_err", err0, 1);
        chk("tmo_prog", prog0, 5);
        @(posedge clk); #1;
        btn_load = 1'b0;
        repeat (20) tick();
        chk("tmo_err1", err1, 1);
        chk("tmo_prog1", prog1, 6);

        // Second load event six cycles after the first: dut1 is still in CONFIRM, dut0 is idle.
        b0 = np0;
        b1 = np1;
        btn_load = 1'b1;
        repeat (5) tick();
        btn_load = 1'b0;
        tick();
        btn_load = 1'b1;
        repeat (20) tick();
        btn_load = 1'b0;
        repeat (20) tick();
        chk("ignored_load1", np1 - b1, 1);
        chk("accepted_load0", np0 - b0, 2);
        stuck = 1'b0;

        // Up and down together cancel.
        press(1'b1, 1'b1, 1'b0, 6);
        chk("updown0", pend0, 5);
        chk("updown1", pend1, 6);

        // Reset while COMMIT is active.
        btn_load = 1'b1;
        wait_upd0(found);
        chk("upd_seen_rst", found, 1);
        rst = 1'b0;
        #1;
        chk("arst_upd", upd0, 0);
        chk("arst_busy", busy0, 0);
        chk("arst_prog", prog0, 0);
        chk("arst_pend", pend0, 0);
        chk("arst_err", err0, 0);
        chk("arst_upd1", upd1, 0);
        btn_load = 1'b0;
        repeat (2) tick();
        rst = 1'b1;
        repeat (8) tick();
        chk("post_busy", busy0, 0);
        chk("post_upd", upd0, 0);
        chk("post_prog", prog0, 0);

        // FSM restarts cleanly from IDLE.
        press(1'b1, 1'b0, 1'b0, 6);
        chk("post_pend", pend0, 1);
        b0 = np0;
        press(1'b0, 1'b0, 1'b1, 6);
        chk("post_commit", prog0, 1);
        chk("post_commit_busy", busy0, 0);
        chk("post_commit_err", err0, 0);
        chk("post_pulses", np0 - b0, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
